dmem_block_responder: RTL

Memory-side responder for the data-memory port driven by the pipelined MIPS core. Serves single-word reads/writes (byte-sized writes, big-endian) and 256-bit cache-block reads/writes through a latency-modelled request/valid handshake. Sits between the core's `data_*_2DM`/`dBlk*` outputs and its `*_fDM` inputs, standing in for main memory in simulation and for cache-refill bring-up.

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/dmem_word_ram.sv | 58 +++++
 rtl/dmem_block_responder.sv | 138 +++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory block responder and its storage.
package dmem_pkg;

    localparam int unsigned WORDS_PER_BLOCK = 8;
    localparam int unsigned BLOCK_BITS      = 256;

    localparam logic [1:0] SZ_WORD = 2'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP,
        ST_RELEASE
    } blk_state_e;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } blk_op_e;

    // Byte count of a word write; the all-zero encoding means a full word.
    function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
        return (size == SZ_WORD) ? 3'd4 : {1'b0, size};
    endfunction

endpackage

// File: rtl/dmem_word_ram.sv
// Word storage organised as eight banks, one per word slot of a cache block, so a
// whole block is read or written in one access alongside the single word port.
module dmem_word_ram
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 10
) (
    input  logic                  i_clk,
    input  logic [ADDR_BITS-1:0]  i_rd_idx,
    output logic [31:0]           o_rd_data,
    input  logic                  i_wr_en,
    input  logic [ADDR_BITS-1:0]  i_wr_idx,
    input  logic [3:0]            i_wr_be,
    input  logic [31:0]           i_wr_data,
    input  logic [ADDR_BITS-4:0]  i_blk_idx,
    output logic [BLOCK_BITS-1:0] o_blk_rd_data,
    input  logic                  i_blk_wr_en,
    input  logic [BLOCK_BITS-1:0] i_blk_wr_data
);

    localparam int unsigned ROWS = 2 ** (ADDR_BITS - 3);

    logic [31:0] w_word_rd [WORDS_PER_BLOCK];

    for (genvar w = 0; w < WORDS_PER_BLOCK; w++) begin : g_bank
        logic [31:0] r_bank [ROWS];
        logic [31:0] w_merged;
        logic        w_word_hit;

        assign w_word_hit = i_wr_en && (i_wr_idx[2:0] == 3'(w));

        // Byte enable k selects big-endian byte offset k, i.e. bits [31-8k -: 8].
        always_comb begin
            w_merged = r_bank[i_wr_idx[ADDR_BITS-1:3]];
            for (int unsigned k = 0; k < 4; k++) begin
                if (i_wr_be[k]) begin
                    w_merged[31-8*k -: 8] = i_wr_data[31-8*k -: 8];
                end
            end
        end

        // The block write is issued last so it wins a same-word collision.
        always_ff @(posedge i_clk) begin
            if (w_word_hit) begin
                r_bank[i_wr_idx[ADDR_BITS-1:3]] <= w_merged;
            end
            if (i_blk_wr_en) begin
                r_bank[i_blk_idx] <= i_blk_wr_data[32*w +: 32];
            end
        end

        assign w_word_rd[w]               = r_bank[i_rd_idx[ADDR_BITS-1:3]];
        assign o_blk_rd_data[32*w +: 32]  = r_bank[i_blk_idx];
    end

    assign o_rd_data = w_word_rd[i_rd_idx[2:0]];

endmodule

// File: rtl/dmem_block_responder.sv
// Memory-side responder for the core's data port: combinational word reads, byte-sized
// word writes, and latency-modelled 256-bit block reads/writes with one-cycle valid pulses.
module dmem_block_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_BITS   = 10,
    parameter int unsigned BLK_LATENCY = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [31:0]           data_address_2DM,
    input  logic                  MemRead_2DM,
    input  logic                  MemWrite_2DM,
    input  logic [31:0]           data_write_2DM,
    input  logic [1:0]            data_write_size_2DM,
    output logic [31:0]           data_read_fDM,
    input  logic                  dBlkRead,
    input  logic                  dBlkWrite,
    input  logic [BLOCK_BITS-1:0] block_write_2DM,
    output logic [BLOCK_BITS-1:0] block_read_fDM,
    output logic                  block_read_fDM_valid,
    output logic                  block_write_fDM_valid
);

    localparam logic [3:0] LAT_LOAD = 4'(BLK_LATENCY - 1);

    blk_state_e            r_state, w_state_nxt;
    logic [3:0]            r_cnt, w_cnt_nxt;
    blk_op_e               r_op;
    logic [ADDR_BITS-4:0]  r_blk_idx;
    logic [BLOCK_BITS-1:0] r_blk_wdata;
    logic [BLOCK_BITS-1:0] r_blk_rd_last;
    logic [BLOCK_BITS-1:0] w_ram_blk;
    logic [31:0]           w_ram_word;
    logic                  w_accept;
    logic                  w_rd_valid;
    logic                  w_wr_valid;
    logic                  w_blk_commit;
    logic [3:0]            w_be;
    logic [31:0]           w_lane_data;
    int unsigned           w_off;
    int unsigned           w_nbytes;
    logic                  w_unused_addr;

    assign w_unused_addr = ^data_address_2DM[31:ADDR_BITS+2];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (dBlkWrite || dBlkRead) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = LAT_LOAD;
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_RESP:    w_state_nxt = ST_RELEASE;
            ST_RELEASE: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_op          <= OP_READ;
            r_blk_rd_last <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_op <= dBlkWrite ? OP_WRITE : OP_READ;
            end
            if (w_rd_valid) begin
                r_blk_rd_last <= w_ram_blk;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_blk_idx   <= data_address_2DM[ADDR_BITS+1:5];
            r_blk_wdata <= block_write_2DM;
        end
    end

    assign w_rd_valid   = (r_state == ST_RESP) && (r_op == OP_READ);
    assign w_wr_valid   = (r_state == ST_RESP) && (r_op == OP_WRITE);
    assign w_blk_commit = w_wr_valid && !RESET;

    // Steer the low n source bytes (MSB first) onto lanes off..off+n-1; lanes past 3 drop.
    assign w_off    = 32'(data_address_2DM[1:0]);
    assign w_nbytes = 32'(size_to_bytes(data_write_size_2DM));

    always_comb begin
        w_be        = '0;
        w_lane_data = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            if (k >= w_off && k < w_off + w_nbytes) begin
                w_be[k] = 1'b1;
                w_lane_data[31-8*k -: 8] =
                    8'(data_write_2DM >> (8 * (w_nbytes - 1 - (k - w_off))));
            end
        end
    end

    dmem_word_ram #(
        .ADDR_BITS(ADDR_BITS)
    ) u_ram (
        .i_clk         (CLK),
        .i_rd_idx      (data_address_2DM[ADDR_BITS+1:2]),
        .o_rd_data     (w_ram_word),
        .i_wr_en       (MemWrite_2DM),
        .i_wr_idx      (data_address_2DM[ADDR_BITS+1:2]),
        .i_wr_be       (w_be),
        .i_wr_data     (w_lane_data),
        .i_blk_idx     (r_blk_idx),
        .o_blk_rd_data (w_ram_blk),
        .i_blk_wr_en   (w_blk_commit),
        .i_blk_wr_data (r_blk_wdata)
    );

    assign data_read_fDM         = MemRead_2DM ? w_ram_word : '0;
    assign block_read_fDM        = w_rd_valid ? w_ram_blk : r_blk_rd_last;
    assign block_read_fDM_valid  = w_rd_valid;
    assign block_write_fDM_valid = w_wr_valid;

endmodule
